// File: rtl/axil_req_arbiter.sv
// ---------------------------------------------------------------------------
// axil_req_arbiter
//
// Shares one AXI-Lite slave port between NREQ simple request/response
// clients. A round-robin arbiter picks one pending request while idle, the
// request is replayed as a full AXI-Lite write (AW+W+B) or read (AR+R), and
// the response is handed back to the requester that issued it. Only one
// transaction is in flight at any time.
//
// Ports
//   ACLK, ARESETn       clock, asynchronous active-low reset
//   req_valid/ready     per-requester request handshake (ready one-hot or 0)
//   req_write           1 = write, 0 = read
//   req_addr/wdata      packed, requester i at [i*WIDTH +: WIDTH]
//   req_wstrb           packed, requester i at [i*WIDTH/8 +: WIDTH/8]
//   rsp_valid/ready     per-requester response handshake (valid one-hot or 0)
//   rsp_rdata/rsp_resp  read data (0 for writes) and BRESP/RRESP
//   AW*/W*/B*/AR*/R*    AXI-Lite master channels towards the shared slave
// ---------------------------------------------------------------------------
module axil_req_arbiter #(
  parameter int NREQ  = 2,
  parameter int WIDTH = 32
) (
  input  logic                      ACLK,
  input  logic                      ARESETn,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0]           req_write,
  input  logic [NREQ*WIDTH-1:0]     req_addr,
  input  logic [NREQ*WIDTH-1:0]     req_wdata,
  input  logic [NREQ*(WIDTH/8)-1:0] req_wstrb,
  output logic [NREQ-1:0]           rsp_valid,
  input  logic [NREQ-1:0]           rsp_ready,
  output logic [WIDTH-1:0]          rsp_rdata,
  output logic [1:0]                rsp_resp,
  output logic                      AWVALID,
  input  logic                      AWREADY,
  output logic [WIDTH-1:0]          AWADDR,
  output logic                      WVALID,
  input  logic                      WREADY,
  output logic [WIDTH-1:0]          WDATA,
  output logic [WIDTH/8-1:0]        WSTRB,
  input  logic                      BVALID,
  output logic                      BREADY,
  input  logic [1:0]                BRESP,
  output logic                      ARVALID,
  input  logic                      ARREADY,
  output logic [WIDTH-1:0]          ARADDR,
  input  logic                      RVALID,
  output logic                      RREADY,
  input  logic [WIDTH-1:0]          RDATA,
  input  logic [1:0]                RRESP
);

  localparam int SW   = WIDTH / 8;
  localparam int IDXW = $clog2(NREQ);
  localparam logic [IDXW:0] NREQ_C = NREQ[IDXW:0];

  typedef enum logic [2:0] {
    ST_IDLE, ST_WADDR, ST_WRESP, ST_RADDR, ST_RDATA, ST_RESP
  } state_t;

  state_t            state_reg;
  logic [IDXW-1:0]   rr_ptr_reg;
  logic [IDXW-1:0]   grant_reg;
  logic [WIDTH-1:0]  addr_reg;
  logic [WIDTH-1:0]  wdata_reg;
  logic [SW-1:0]     wstrb_reg;
  logic              awvalid_reg;
  logic              wvalid_reg;
  logic              bready_reg;
  logic              arvalid_reg;
  logic              rready_reg;
  logic [NREQ-1:0]   rsp_valid_reg;
  logic [WIDTH-1:0]  rsp_rdata_reg;
  logic [1:0]        rsp_resp_reg;

  // Unpacked views of the requester buses
  logic [WIDTH-1:0] addr_arr  [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];
  logic [SW-1:0]    wstrb_arr [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]  = req_addr[gi*WIDTH +: WIDTH];
      assign wdata_arr[gi] = req_wdata[gi*WIDTH +: WIDTH];
      assign wstrb_arr[gi] = req_wstrb[gi*SW +: SW];
    end
  endgenerate

  // Round-robin search starting at rr_ptr_reg, wrapping at NREQ (which need
  // not be a power of two, hence the explicit subtract instead of a mask).
  logic            win_found;
  logic [IDXW-1:0] win_idx;
  logic [IDXW:0]   cand;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = {1'b0, rr_ptr_reg} + k[IDXW:0];
      if (cand >= NREQ_C) cand = cand - NREQ_C;
      if (!win_found && req_valid[cand[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDXW-1:0];
      end
    end
  end

  logic [IDXW:0]   nxt_sum;
  logic [IDXW-1:0] rr_next;
  logic [NREQ-1:0] win_onehot;
  logic [NREQ-1:0] grant_onehot;

  assign nxt_sum      = {1'b0, win_idx} + {{IDXW{1'b0}}, 1'b1};
  assign rr_next      = (nxt_sum == NREQ_C) ? '0 : nxt_sum[IDXW-1:0];
  assign win_onehot   = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  assign grant_onehot = {{(NREQ-1){1'b0}}, 1'b1} << grant_reg;

  // Gated by ARESETn so the combinational ready is also 0 while in reset.
  assign req_ready = (ARESETn && state_reg == ST_IDLE && win_found) ? win_onehot : '0;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_reg     <= ST_IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      addr_reg      <= '0;
      wdata_reg     <= '0;
      wstrb_reg     <= '0;
      awvalid_reg   <= 1'b0;
      wvalid_reg    <= 1'b0;
      bready_reg    <= 1'b0;
      arvalid_reg   <= 1'b0;
      rready_reg    <= 1'b0;
      rsp_valid_reg <= '0;
      rsp_rdata_reg <= '0;
      rsp_resp_reg  <= 2'b00;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          // win_found implies req_valid of the winner, i.e. acceptance
          if (win_found) begin
            grant_reg  <= win_idx;
            rr_ptr_reg <= rr_next;
            addr_reg   <= addr_arr[win_idx];
            wdata_reg  <= wdata_arr[win_idx];
            wstrb_reg  <= wstrb_arr[win_idx];
            if (req_write[win_idx]) begin
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= ST_WADDR;
            end else begin
              arvalid_reg <= 1'b1;
              state_reg   <= ST_RADDR;
            end
          end
        end
        ST_WADDR: begin
          // AW and W retire independently; move on once neither is pending
          if (AWREADY) awvalid_reg <= 1'b0;
          if (WREADY)  wvalid_reg  <= 1'b0;
          if ((!awvalid_reg || AWREADY) && (!wvalid_reg || WREADY)) begin
            bready_reg <= 1'b1;
            state_reg  <= ST_WRESP;
          end
        end
        ST_WRESP: begin
          if (BVALID) begin
            bready_reg    <= 1'b0;
            rsp_resp_reg  <= BRESP;
            rsp_rdata_reg <= '0;
            rsp_valid_reg <= grant_onehot;
            state_reg     <= ST_RESP;
          end
        end
        ST_RADDR: begin
          if (ARREADY) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (RVALID) begin
            rready_reg    <= 1'b0;
            rsp_rdata_reg <= RDATA;
            rsp_resp_reg  <= RRESP;
            rsp_valid_reg <= grant_onehot;
            state_reg     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (rsp_ready[grant_reg]) begin
            rsp_valid_reg <= '0;
            state_reg     <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign rsp_resp  = rsp_resp_reg;
  assign AWVALID   = awvalid_reg;
  assign AWADDR    = addr_reg;
  assign WVALID    = wvalid_reg;
  assign WDATA     = wdata_reg;
  assign WSTRB     = wstrb_reg;
  assign BREADY    = bready_reg;
  assign ARVALID   = arvalid_reg;
  assign ARADDR    = addr_reg;
  assign RREADY    = rready_reg;

endmodule

// File: doc/axil_req_arbiter.md
Name: axil_req_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one AXI-Lite slave port (such as the emulator's AXI-Lite RTL adapter top) between NREQ simple request/response clients.
- Each accepted request is turned into a full AXI-Lite write (AW+W+B) or read (AR+R) transaction.
- The response is returned to the granted requester.
- Exactly one transaction is outstanding at a time.

Parameters:
NREQ, 2, number of requesters (2..8)
WIDTH, 32, address/data width; strobe width is WIDTH/8

Ports:
ACLK  in  1  clock
ARESETn  in  1  asynchronous active-low reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester request accept, one-hot or zero
req_write  in  NREQ  1=write, 0=read
req_addr  in  NREQ*WIDTH  packed addresses, requester i at [i*WIDTH +: WIDTH]
req_wdata  in  NREQ*WIDTH  packed write data
req_wstrb  in  NREQ*WIDTH/8  packed write strobes
rsp_valid  out  NREQ  response valid, one-hot or zero
rsp_ready  in  NREQ  response accept
rsp_rdata  out  WIDTH  read data (0 for writes)
rsp_resp  out  2  BRESP or RRESP of the completed transaction
AWVALID  out  1  write address valid
AWREADY  in  1  write address ready
AWADDR  out  WIDTH  write address
WVALID  out  1  write data valid
WREADY  in  1  write data ready
WDATA  out  WIDTH  write data
WSTRB  out  WIDTH/8  write strobes
BVALID  in  1  write response valid
BREADY  out  1  write response ready
BRESP  in  2  write response
ARVALID  out  1  read address valid
ARREADY  in  1  read address ready
ARADDR  out  WIDTH  read address
RVALID  in  1  read data valid
RREADY  out  1  read data ready
RDATA  in  WIDTH  read data
RRESP  in  2  read response

Behaviour:
Reset:
- On ARESETn low, immediately (asynchronously) force all outputs to 0, state to IDLE and RR pointer to 0.
- Reset mid-transaction abandons the transaction; no response is delivered.

Arbitration:
- In IDLE, grant the first requester with req_valid=1, searching from the RR pointer upward with wrap.
- req_ready[g] is combinational and high only in IDLE for the winner.
- Acceptance occurs on req_valid[g] & req_ready[g] at the clock edge.
- On acceptance, latch write/addr/wdata/wstrb of g and the grant index. Set the RR pointer to (g+1) mod NREQ.

FSM states: IDLE, WADDR, WRESP, RADDR, RDATA, RESP.
- IDLE -> WADDR (write) or RADDR (read) on acceptance.
- WADDR: AWVALID and WVALID both rise the cycle after acceptance.
  - Each drops independently after its own handshake (AWVALID&AWREADY, WVALID&WREADY).
  - Both handshakes may complete in the same cycle or in either order.
  - When both are done -> WRESP.
- WRESP: BREADY=1. On BVALID, capture BRESP, set rdata=0 -> RESP.
- RADDR: ARVALID=1 until ARREADY -> RDATA.
- RDATA: RREADY=1. On RVALID, capture RDATA and RRESP -> RESP.
- RESP: rsp_valid[g]=1 with rsp_rdata/rsp_resp stable until rsp_ready[g] -> IDLE. No new grant until IDLE.

AXI rules:
- Valid signals never drop before their handshake.
- Address/data/strobe outputs are stable while the corresponding valid is high.

Latency:
- Zero-wait slave: accept at cycle 0, AW/W handshake at cycle 1, B at cycle 2, rsp_valid at cycle 3.
- With rsp_ready=1, IDLE is re-entered at cycle 4, so the next grant is at cycle 4.

Error responses (SLVERR/DECERR) are passed through unchanged; no retry.

Requester i's req_valid may drop without being accepted; that is not a protocol error, and the request is ignored.

Test Plan:
1. After reset, requester 0 writes addr 0x10, data 0xDEADBEEF, wstrb 0xF; slave zero-wait, BRESP=0 -> AWADDR=0x10, WDATA=0xDEADBEEF, rsp_valid[0] at cycle 3, rsp_resp=0, rsp_rdata=0.
2. Requester 1 reads 0x20; slave ARREADY after 2 cycles, RVALID with 0x12345678 and RRESP=2 -> rsp_valid[1], rsp_rdata=0x12345678, rsp_resp=2.
3. Both requesters hold req_valid continuously -> grants alternate 0,1,0,1 across 4 transactions, and at most one req_ready is ever high.
4. WREADY arrives 3 cycles before AWREADY, then both in the same cycle on the next write -> WVALID drops individually, BREADY rises only after both handshakes, and each write yields exactly one response.
5. rsp_ready[0] held low for 5 cycles -> rsp_valid[0] and rsp_rdata stay stable, and requester 1's pending request is not granted until after the rsp_ready handshake.
6. ARESETn is pulsed low while ARVALID=1 -> ARVALID goes to 0 without a clock edge. After release the FSM is in IDLE, the pointer is 0, and requester 0 wins a simultaneous request.
